// File: rtl/twos_comp_seq.sv
// Multi-cycle two's-complement unit: pass, negate, abs and one's complement.
// It converts one CHUNK-bit slice per cycle and keeps the ripple carry in a register.
module twos_comp_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] in_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] out_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] out_q;
  logic [IdxW-1:0]  idx_q;
  logic             inv_q;
  logic             cen_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic             done_q;
  logic             ready_q;

  logic [CHUNK-1:0] slice;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] res_d;
  logic             inv_d;
  logic             cen_d;

  always_comb begin
    inv_d = (mode_i == 2'b01) | (mode_i == 2'b11) | ((mode_i == 2'b10) & in_i[WIDTH-1]);
    cen_d = (mode_i != 2'b11);
    slice = op_q[idx_q*CHUNK +: CHUNK];
    sum   = {1'b0, ~slice} + {{CHUNK{1'b0}}, carry_q};
    // The result register is updated in place, one slice at a time.
    res_d = out_q;
    res_d[idx_q*CHUNK +: CHUNK] = inv_q ? sum[CHUNK-1:0] : slice;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      op_q    <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      inv_q   <= 1'b0;
      cen_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_i) begin
            op_q    <= in_i;
            inv_q   <= inv_d;
            cen_q   <= cen_d;
            carry_q <= inv_d & cen_d;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            ready_q <= 1'b0;
            state_q <= StRun;
          end
        end
        StRun: begin
          out_q   <= res_d;
          carry_q <= sum[CHUNK];
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            // The final carry-out is dropped, so negating zero gives zero.
            ovf_q   <= inv_q & cen_q & (op_q == MostNeg);
            zero_q  <= (res_d == '0);
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign out_o   = out_q;
  assign ovf_o   = ovf_q;
  assign zero_o  = zero_q;

endmodule
